// File: rtl/fsm_leer_rtc.sv
// Read-side RTC bus sequencer: sends the transfer command, then reads N_REG registers as address/read pairs.
// Read bytes land in shadow registers and are committed to reg_data together, so a partial set is never visible.
module fsm_leer_rtc #(
  parameter int         N_REG     = 6,
  parameter logic [7:0] BASE_ADDR = 8'h21,
  parameter logic [7:0] XFER_CMD  = 8'hF0,
  parameter int         WAIT_MAX  = 255
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 Inicio_R,
  input  logic                 Final_WR,
  input  logic [7:0]           dato_in,
  output logic [4:0]           ctrl_R,
  output logic                 op_start,
  output logic                 op_rd,
  output logic [7:0]           dir_out,
  output logic [8*N_REG-1:0]   reg_data,
  output logic                 listo,
  output logic                 ocupado,
  output logic                 error
);

  // Handshake: op_start pulses in the first cycle of a bus step, with op_rd/dir_out
  // already valid and held for the whole step; the step ends in the first later cycle
  // where Final_WR=1 (Final_WR in the op_start cycle itself is ignored).

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_XFER = 3'd1,
    S_ADDR = 3'd2,
    S_READ = 3'd3,
    S_DONE = 3'd4
  } state_t;

  state_t               r_state, w_state_n;
  logic [3:0]           r_idx, w_idx_n;
  logic                 r_first, w_first_n;
  logic [7:0]           r_cnt, w_cnt_n;
  logic                 r_error, w_err_n;
  logic [4:0]           r_ctrl, w_ctrl_n;
  logic                 r_op_rd, w_rd_n;
  logic [7:0]           r_dir, w_dir_n;
  logic                 r_listo;
  logic [8*N_REG-1:0]   r_shadow, r_reg;
  logic                 w_cap, w_commit, w_clr_shadow;

  always_comb begin
    w_state_n    = r_state;
    w_idx_n      = r_idx;
    w_first_n    = 1'b0;
    w_cnt_n      = r_cnt;
    w_err_n      = r_error;
    w_cap        = 1'b0;
    w_commit     = 1'b0;
    w_clr_shadow = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (Inicio_R) begin
          w_state_n    = S_XFER;
          w_idx_n      = 4'd0;
          w_first_n    = 1'b1;
          w_err_n      = 1'b0;
          w_clr_shadow = 1'b1;
        end
      end
      S_XFER, S_ADDR, S_READ: begin
        if (r_first) begin
          w_cnt_n = 8'd0;
        end else if (Final_WR) begin
          w_first_n = 1'b1;
          if (r_state == S_XFER) begin
            w_state_n = S_ADDR;
            w_idx_n   = 4'd0;
          end else if (r_state == S_ADDR) begin
            w_state_n = S_READ;
          end else begin
            w_cap = 1'b1;
            if (r_idx == 4'(N_REG - 1)) begin
              w_state_n = S_DONE;
              w_first_n = 1'b0;
            end else begin
              w_state_n = S_ADDR;
              w_idx_n   = r_idx + 4'd1;
            end
          end
        end else if (r_cnt == 8'(WAIT_MAX - 1)) begin
          // Generator never answered: abandon the sequence, keep the last committed set.
          w_state_n    = S_IDLE;
          w_err_n      = 1'b1;
          w_clr_shadow = 1'b1;
        end else begin
          w_cnt_n = r_cnt + 8'd1;
        end
      end
      S_DONE: begin
        w_commit  = 1'b1;
        w_state_n = S_IDLE;
      end
      default: w_state_n = S_IDLE;
    endcase

    w_ctrl_n = 5'd0;
    w_rd_n   = 1'b0;
    w_dir_n  = 8'd0;
    case (w_state_n)
      S_XFER: begin
        w_ctrl_n = 5'd1;
        w_dir_n  = XFER_CMD;
      end
      S_ADDR: begin
        w_ctrl_n = 5'd2 + {w_idx_n, 1'b0};
        w_dir_n  = BASE_ADDR + {4'd0, w_idx_n};
      end
      S_READ: begin
        w_ctrl_n = 5'd3 + {w_idx_n, 1'b0};
        w_rd_n   = 1'b1;
        w_dir_n  = BASE_ADDR + {4'd0, w_idx_n};
      end
      S_DONE:  w_ctrl_n = 5'(2 * N_REG + 2);
      default: w_ctrl_n = 5'd0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_idx    <= 4'd0;
      r_first  <= 1'b0;
      r_cnt    <= 8'd0;
      r_error  <= 1'b0;
      r_ctrl   <= 5'd0;
      r_op_rd  <= 1'b0;
      r_dir    <= 8'd0;
      r_listo  <= 1'b0;
      r_shadow <= '0;
      r_reg    <= '0;
    end else begin
      r_state <= w_state_n;
      r_idx   <= w_idx_n;
      r_first <= w_first_n;
      r_cnt   <= w_cnt_n;
      r_error <= w_err_n;
      r_ctrl  <= w_ctrl_n;
      r_op_rd <= w_rd_n;
      r_dir   <= w_dir_n;
      r_listo <= (w_state_n == S_DONE);
      if (w_clr_shadow) begin
        r_shadow <= '0;
      end else begin
        for (int i = 0; i < N_REG; i++) begin
          if (w_cap && r_idx == 4'(i)) r_shadow[8*i +: 8] <= dato_in;
        end
      end
      if (w_commit) r_reg <= r_shadow;
    end
  end

  assign ctrl_R   = r_ctrl;
  assign op_start = r_first;
  assign op_rd    = r_op_rd;
  assign dir_out  = r_dir;
  assign reg_data = r_reg;
  assign listo    = r_listo;
  assign ocupado  = (r_state != S_IDLE);
  assign error    = r_error;

endmodule

// File: tb/tb_fsm_leer_rtc.sv
// Bench for fsm_leer_rtc: a step-indexed behavioural model predicts every output each cycle,
// directed scenarios pin timing/data with literal values, then a randomized phase follows.
module tb_fsm_leer_rtc;

  localparam int         N     = 6;
  localparam int         W     = 8 * N;
  localparam logic [7:0] BASE  = 8'h21;
  localparam logic [7:0] CMD   = 8'hF0;
  localparam int         WMAX  = 255;

  logic         clk;
  logic         reset;
  logic         Inicio_R;
  logic         Final_WR;
  logic [7:0]   dato_in;
  logic [4:0]   ctrl_R;
  logic         op_start;
  logic         op_rd;
  logic [7:0]   dir_out;
  logic [W-1:0] reg_data;
  logic         listo;
  logic         ocupado;
  logic         error;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  fsm_leer_rtc #(.N_REG(N), .BASE_ADDR(BASE), .XFER_CMD(CMD), .WAIT_MAX(WMAX)) dut (
    .clk(clk), .reset(reset), .Inicio_R(Inicio_R), .Final_WR(Final_WR), .dato_in(dato_in),
    .ctrl_R(ctrl_R), .op_start(op_start), .op_rd(op_rd), .dir_out(dir_out),
    .reg_data(reg_data), .listo(listo), .ocupado(ocupado), .error(error)
  );

  // clock / reset block
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Behavioural model: sequence is a list of 2N+1 bus steps (k=0..2N) then DONE (k=2N+1).
  // Step k has code k+1; odd k>0 addresses register (k-1)/2, even k>=2 reads register (k-2)/2.
  logic         m_valid  = 1'b0;
  logic         m_active = 1'b0;
  int           m_k      = 0;
  int           m_age    = 0;
  int           m_wait   = 0;
  logic [W-1:0] m_shadow = '0;
  logic [W-1:0] m_reg    = '0;
  logic         m_err    = 1'b0;

  always @(posedge clk) begin
    if (reset) begin
      m_valid <= 1'b1; m_active <= 1'b0; m_k <= 0; m_age <= 0; m_wait <= 0;
      m_shadow <= '0; m_reg <= '0; m_err <= 1'b0;
    end else if (!m_active) begin
      if (Inicio_R) begin
        m_active <= 1'b1; m_k <= 0; m_age <= 0; m_err <= 1'b0;
      end
    end else if (m_k == 2*N + 1) begin
      m_reg    <= m_shadow;
      m_active <= 1'b0;
    end else if (m_age == 0) begin
      m_age  <= 1;
      m_wait <= 0;
    end else if (Final_WR) begin
      if (m_k >= 2 && m_k % 2 == 0) m_shadow[8*((m_k-2)/2) +: 8] <= dato_in;
      m_k   <= m_k + 1;
      m_age <= 0;
    end else if (m_wait == WMAX - 1) begin
      m_err    <= 1'b1;
      m_active <= 1'b0;
    end else begin
      m_wait <= m_wait + 1;
    end
  end

  // Timing generator driver: mode 0 answers g_delay cycles after op_start,
  // mode 1 holds Final_WR high, mode 2 never answers the ADDR_2 write.
  int   g_mode  = 0;
  int   g_delay = 3;
  int   g_cnt   = 0;
  logic g_fixed = 1'b0;

  always @(negedge clk) begin
    if (g_mode == 1) begin
      Final_WR = 1'b1;
    end else begin
      if (g_cnt > 0) begin
        g_cnt    = g_cnt - 1;
        Final_WR = (g_cnt == 0);
      end else begin
        Final_WR = 1'b0;
      end
      if (op_start && !(g_mode == 2 && dir_out == 8'h23 && !op_rd)) g_cnt = g_delay;
    end
    dato_in = g_fixed ? 8'(8'h10 + (dir_out - BASE)) : 8'($urandom);
  end

  // Monitor + per-cycle compare against the model
  int         n_ops   = 0;
  int         n_listo = 0;
  int         n_xfer  = 0;
  int         n_busy  = 0;
  int         n_code6 = 0;
  logic [7:0] dir_log[$];

  always @(negedge clk) begin
    logic         e_bus, e_start, e_rd, e_listo, e_busy;
    logic [4:0]   e_ctrl;
    logic [7:0]   e_dir;
    cyc = cyc + 1;
    if (m_valid && !$isunknown(reset) && !reset) begin
      if (op_start) begin
        n_ops = n_ops + 1;
        dir_log.push_back(dir_out);
        if (dir_out == CMD && !op_rd && ctrl_R == 5'd1) n_xfer = n_xfer + 1;
      end
      if (listo) n_listo = n_listo + 1;
      if (ocupado) n_busy = n_busy + 1;
      if (ctrl_R == 5'd6) n_code6 = n_code6 + 1;
    end
    if (m_valid) begin
      e_bus   = m_active && (m_k <= 2*N);
      e_ctrl  = m_active ? 5'(m_k + 1) : 5'd0;
      e_start = e_bus && (m_age == 0);
      e_rd    = e_bus && (m_k >= 2) && (m_k % 2 == 0);
      e_dir   = !e_bus ? 8'd0 : (m_k == 0) ? CMD : 8'(BASE + 8'((m_k - 1) / 2));
      e_listo = m_active && (m_k == 2*N + 1);
      e_busy  = m_active;
      checks  = checks + 1;
      if (ctrl_R !== e_ctrl || op_start !== e_start || op_rd !== e_rd || dir_out !== e_dir ||
          reg_data !== m_reg || listo !== e_listo || ocupado !== e_busy || error !== m_err) begin
        failures = failures + 1;
        $display("FAIL model cyc=%0d got ctrl=%0d st=%b rd=%b dir=%h reg=%h listo=%b ocu=%b err=%b exp ctrl=%0d st=%b rd=%b dir=%h reg=%h listo=%b ocu=%b err=%b",
                 cyc, ctrl_R, op_start, op_rd, dir_out, reg_data, listo, ocupado, error,
                 e_ctrl, e_start, e_rd, e_dir, m_reg, e_listo, e_busy, m_err);
      end
    end
  end

  // driver tasks
  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks = checks + 1;
    if (got !== exp) begin
      failures = failures + 1;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  task automatic start_seq();
    Inicio_R = 1'b1;
    step();
    Inicio_R = 1'b0;
    step();
  endtask

  task automatic wait_idle(input string name, input int bound);
    int n = 0;
    while (ocupado && n < bound) begin
      step();
      n++;
    end
    chk({name, "_idle_timeout"}, {63'd0, ocupado}, 64'd0);
  endtask

  task automatic wait_code(input string name, input logic [4:0] code, input int bound);
    int n = 0;
    while (ctrl_R !== code && n < bound) begin
      step();
      n++;
    end
    chk({name, "_code_timeout"}, {59'd0, ctrl_R}, {59'd0, code});
  endtask

  logic [7:0] exp_q[$];

  initial begin
    int b_ops, b_listo, b_xfer, b_busy, b_code6;
    Inicio_R = 1'b0;
    reset    = 1'b1;
    repeat (3) step();
    chk("rst_ctrl", {59'd0, ctrl_R}, 64'd0);
    chk("rst_reg", {16'd0, reg_data}, 64'd0);
    chk("rst_busy_err", {62'd0, ocupado, error}, 64'd0);
    chk("rst_start_listo", {62'd0, op_start, listo}, 64'd0);
    reset = 1'b0;
    step();

    // 1: nominal read, answer 3 cycles after each op_start, data 10h+i
    g_mode = 0; g_delay = 3; g_fixed = 1'b1;
    b_ops = n_ops; b_listo = n_listo;
    start_seq();
    wait_idle("t1", 500);
    chk("t1_ops", 64'(n_ops - b_ops), 64'd13);
    chk("t1_listo", 64'(n_listo - b_listo), 64'd1);
    chk("t1_reg", {16'd0, reg_data}, 64'h0000_1514_1312_1110);
    exp_q.delete();
    exp_q.push_back(CMD);
    for (int i = 0; i < N; i++) begin
      exp_q.push_back(8'(BASE + 8'(i)));
      exp_q.push_back(8'(BASE + 8'(i)));
    end
    for (int j = b_ops; j < n_ops && exp_q.size() > 0; j++) begin
      chk($sformatf("t1_dir%0d", j - b_ops), {56'd0, dir_log[j]}, {56'd0, exp_q.pop_front()});
    end

    // 2: Final_WR held high -> every bus step lasts exactly 2 cycles
    g_mode = 1; g_fixed = 1'b0;
    b_busy = n_busy; b_listo = n_listo;
    start_seq();
    wait_idle("t2", 500);
    chk("t2_busy_cycles", 64'(n_busy - b_busy), 64'd27);
    chk("t2_listo", 64'(n_listo - b_listo), 64'd1);

    // 3: ADDR_2 never answered -> timeout after 255 wait cycles
    g_mode = 2; g_delay = 2;
    b_code6 = n_code6; b_listo = n_listo;
    start_seq();
    wait_idle("t3", 2000);
    chk("t3_error", {63'd0, error}, 64'd1);
    chk("t3_addr2_cycles", 64'(n_code6 - b_code6), 64'd256);
    chk("t3_listo", 64'(n_listo - b_listo), 64'd0);
    chk("t3_reg_kept", {16'd0, reg_data}, {16'd0, m_reg});

    // 4: restart clears error and commits a fresh set
    g_mode = 0; g_delay = 1; g_fixed = 1'b1;
    b_listo = n_listo;
    Inicio_R = 1'b1;
    step();
    Inicio_R = 1'b0;
    chk("t4_err_clear", {63'd0, error}, 64'd0);
    step();
    wait_idle("t4", 500);
    chk("t4_listo", 64'(n_listo - b_listo), 64'd1);
    chk("t4_reg", {16'd0, reg_data}, 64'h0000_1514_1312_1110);

    // 5: start request during READ_1 is ignored
    g_delay = 2; g_fixed = 1'b0;
    b_xfer = n_xfer; b_listo = n_listo;
    start_seq();
    wait_code("t5", 5'd5, 200);
    Inicio_R = 1'b1;
    step();
    Inicio_R = 1'b0;
    wait_idle("t5", 500);
    chk("t5_xfer_once", 64'(n_xfer - b_xfer), 64'd1);
    chk("t5_listo", 64'(n_listo - b_listo), 64'd1);

    // 6: reset during READ_4
    start_seq();
    wait_code("t6", 5'd11, 300);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("t6_ctrl", {59'd0, ctrl_R}, 64'd0);
    chk("t6_start", {63'd0, op_start}, 64'd0);
    chk("t6_reg", {16'd0, reg_data}, 64'd0);
    chk("t6_busy_err", {62'd0, ocupado, error}, 64'd0);
    step();

    // randomized phase: random latencies/data, occasional hangs, stray starts and resets
    for (int it = 0; it < 30; it++) begin
      int r;
      g_delay = $urandom_range(1, 6);
      r = $urandom_range(0, 9);
      g_mode = (r == 0) ? 2 : (r < 3) ? 1 : 0;
      start_seq();
      if ($urandom_range(0, 5) == 0) begin
        repeat ($urandom_range(3, 40)) begin
          Inicio_R = ($urandom_range(0, 15) == 0);
          step();
        end
        Inicio_R = 1'b0;
        reset = 1'b1;
        step();
        reset = 1'b0;
      end else begin
        for (int n = 0; n < 2000 && ocupado; n++) begin
          Inicio_R = ($urandom_range(0, 19) == 0);
          step();
        end
        Inicio_R = 1'b0;
        wait_idle("rnd", 400);
      end
      repeat ($urandom_range(0, 3)) step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
